sd_spi_init_ctrl: RTL and testbench
===================================

// Module: sd_spi_init_ctrl
// PURPOSE
//   SD card SPI-mode power-up initialiser downstream of the SD PLL. Runs on PLL clkout0 (50 MHz)
//   and is gated by pll_lock. Drives the 74+ dummy clocks, then CMD0 -> CMD8 -> (CMD55+ACMD41)*
//   at an identification-rate SCK. Raises init_done, or init_err with a code, for the data-path controller.
// PARAMETERS
//   CLK_DIV      125   clk cycles per SCK half-period (50 MHz/250 = 200 kHz); legal 2..1023
//   DUMMY_CLKS   80    SCK pulses with cs_n=1, mosi=1 before CMD0; legal 74..255
//   NCR_MAX      8     max 0xFF bytes polled for an R1 start (MSB=0) before timeout
//   ACMD41_TRIES 1000  max CMD55+ACMD41 pairs before error
// PORTS
//   clk        in   1  PLL clkout0
//   rst_n      in   1  async active-low reset
//   pll_lock   in   1  PLL lock, async to clk; 2-FF synchronised internally
//   sd_miso    in   1  card DO
//   sd_sck     out  1  SPI clock, idle low (mode 0)
//   sd_cs_n    out  1  card select, active low
//   sd_mosi    out  1  card DI
//   init_done  out  1  card ready (ACMD41 R1=0x00); level, held until reset or lock loss
//   init_err   out  1  init failed; level, sticky until reset or lock loss
//   err_code   out  3  0 none, 1 CMD0 fail, 2 CMD8 fail, 3 ACMD41 tries exhausted, 4 R1 timeout on CMD55/ACMD41
// BEHAVIOUR
//   Reset: sd_sck=0, sd_cs_n=1, sd_mosi=1, init_done=0, init_err=0, err_code=0, FSM=WAIT_LOCK.
//   SCK gen: half-period counter 0..CLK_DIV-1; runs only in shifting states. mosi updates on the
//     clk where SCK falls (first bit set up one half-period before the first rise); miso sampled on the clk where SCK rises.
//     Bytes are MSB first; a byte is exactly 8 SCK pulses. Between bytes SCK stays continuous.
//   FSM: WAIT_LOCK -> (lock_sync=1) DUMMY -> CMD0 -> R1 -> CMD8 -> R7 -> CMD55 -> R1 -> ACMD41 -> R1
//     -> DONE | ERR. A GAP state sits before every command: one 0xFF byte with cs_n=1, then cs_n=0.
//   Frames (6 bytes): CMD0 40 00 00 00 00 95; CMD8 48 00 00 01 AA 87; CMD55 77 00 00 00 00 01;
//     ACMD41 69 40 00 00 00 01. cs_n stays low from first command byte to end of response.
//   R1 wait: after byte 6, shift 0xFF bytes; the first byte with bit7=0 is R1. None within NCR_MAX
//     bytes -> timeout. CMD0 expects 0x01 (else err 1). CMD8 expects R1=0x01, then 4 more bytes
//     whose low 12 bits equal 0x1AA (else err 2; R1 with the illegal-cmd bit 0x05 is also err 2, v1 cards unsupported).
//     CMD55 accepts 0x00 or 0x01. ACMD41: 0x00 -> DONE; 0x01 -> try_cnt++, back to GAP/CMD55;
//     try_cnt reaching ACMD41_TRIES -> err 3; any other R1 or timeout on CMD55/ACMD41 -> err 4.
//   DONE: cs_n=1, sck=0, mosi=1, init_done=1 on the clk after the last R1 bit. ERR: same pins, init_err=1,
//     err_code latched; init_done and init_err are never both 1.
//   Lock loss: lock_sync=0 in any state -> next clk: WAIT_LOCK, cs_n=1, sck=0, done/err/err_code
//     cleared, counters cleared; re-lock restarts from DUMMY (no partial-byte output).
//   Latency: lock_sync rise to first SCK rise = CLK_DIV clks (+2 sync).
// TESTING  (bench uses CLK_DIV=2, behavioural SPI card model)
//   1 Card answers 01, 01+000001AA, ACMD41 01,01,00 -> exactly 80 dummy pulses with cs_n=1; 3 ACMD41
//     frames on mosi; init_done=1, err_code=0; sck idle low afterwards.
//   2 Card holds miso=1 after CMD0 -> 8 FF bytes polled, then init_err=1, err_code=1, cs_n=1.
//   3 CMD8 echo 0x0155 -> err_code=2; CMD8 R1=0x05 -> err_code=2.
//   4 ACMD41_TRIES=3, card always returns 0x01 -> exactly 3 CMD55/ACMD41 pairs, then err_code=3.
//   5 Drop pll_lock mid-CMD8 byte 3 -> within 3 clks cs_n=1, sck=0; re-lock -> full sequence to init_done.
//   6 Assert rst_n=0 asynchronously mid-R1 -> all outputs at reset values immediately, no clk edge needed.

Source files
------------

// File: rtl/sd_spi_init_ctrl.sv
`default_nettype none
// ============================================================================
// sd_spi_init_ctrl : SD card SPI-mode power-up initialiser (dummy clocks,
//                    CMD0 -> CMD8 -> (CMD55 + ACMD41)* at identification SCK)
// Rev 1.0
// ============================================================================
module sd_spi_init_ctrl #(
  parameter int CLK_DIV      = 125,
  parameter int DUMMY_CLKS   = 80,
  parameter int NCR_MAX      = 8,
  parameter int ACMD41_TRIES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sd_miso,
  output logic       sd_sck,
  output logic       sd_cs_n,
  output logic       sd_mosi,
  output logic       init_done,
  output logic       init_err,
  output logic [2:0] err_code
);

  localparam int DIV_W = 10;
  localparam int TRY_W = $clog2(ACMD41_TRIES + 1);
  localparam int NCR_W = $clog2(NCR_MAX + 1);

  localparam logic [1:0] SEL_CMD0   = 2'd0;
  localparam logic [1:0] SEL_CMD8   = 2'd1;
  localparam logic [1:0] SEL_CMD55  = 2'd2;
  localparam logic [1:0] SEL_ACMD41 = 2'd3;

  typedef enum logic [2:0] {
    S_WAIT_LOCK, S_DUMMY, S_GAP, S_CMD, S_R1, S_R7, S_DONE, S_ERR
  } state_t;

  function automatic logic [7:0] frame_byte(input logic [1:0] sel, input logic [2:0] idx);
    logic [47:0] f;
    case (sel)
      SEL_CMD0:  f = 48'h40_0000_0000_95;
      SEL_CMD8:  f = 48'h48_0000_01AA_87;
      SEL_CMD55: f = 48'h77_0000_0000_01;
      default:   f = 48'h69_4000_0000_01;
    endcase
    case (idx)
      3'd0:    frame_byte = f[47:40];
      3'd1:    frame_byte = f[39:32];
      3'd2:    frame_byte = f[31:24];
      3'd3:    frame_byte = f[23:16];
      3'd4:    frame_byte = f[15:8];
      3'd5:    frame_byte = f[7:0];
      default: frame_byte = 8'hFF;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_sync_q, lock_sync_d;
  logic [1:0]       sel_q, sel_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             cs_n_q, cs_n_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [7:0]       dummy_q, dummy_d;
  logic [NCR_W-1:0] ncr_q, ncr_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [3:0]       r7_q, r7_d;
  logic [2:0]       err_code_q, err_code_d;

  logic             shifting, tick, rise, fall, byte_end;
  logic             go_gap, go_err, go_done;
  logic [2:0]       err_val;
  logic [1:0]       next_sel;

  assign shifting = (state_q inside {S_DUMMY, S_GAP, S_CMD, S_R1, S_R7});
  assign tick     = shifting && (div_q == DIV_W'(CLK_DIV - 1));
  assign rise     = tick && !sck_q;
  assign fall     = tick && sck_q;
  assign byte_end = fall && (bit_q == 3'd7);

  always_comb begin
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;
    state_d     = state_q;
    sel_d       = sel_q;
    div_d       = div_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    dummy_d     = dummy_q;
    ncr_d       = ncr_q;
    try_d       = try_q;
    r7_d        = r7_q;
    err_code_d  = err_code_q;
    go_gap      = 1'b0;
    go_err      = 1'b0;
    go_done     = 1'b0;
    err_val     = 3'd0;
    next_sel    = sel_q;

    // mosi shifts on the SCK fall, miso is captured on the SCK rise
    if (shifting) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) sck_d = ~sck_q;
      if (rise) rx_d = {rx_q[6:0], sd_miso};
      if (fall) begin
        bit_d = bit_q + 3'd1;
        tx_d  = {tx_q[6:0], 1'b1};
      end
    end

    case (state_q)
      S_WAIT_LOCK: begin
        // preload so the first SCK rise lands CLK_DIV clocks after lock
        if (lock_sync_q) begin
          state_d = S_DUMMY;
          div_d   = DIV_W'(1);
        end
      end
      S_DUMMY: begin
        if (fall) begin
          dummy_d = dummy_q + 8'd1;
          if (dummy_q == 8'(DUMMY_CLKS - 1)) begin
            state_d = S_GAP;
            bit_d   = 3'd0;
            dummy_d = 8'd0;
          end
        end
      end
      S_GAP: begin
        if (byte_end) begin
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          byte_d  = 3'd0;
          tx_d    = frame_byte(sel_q, 3'd0);
        end
      end
      S_CMD: begin
        if (byte_end) begin
          if (byte_q == 3'd5) begin
            state_d = S_R1;
            ncr_d   = '0;
            tx_d    = 8'hFF;
          end else begin
            byte_d = byte_q + 3'd1;
            tx_d   = frame_byte(sel_q, byte_q + 3'd1);
          end
        end
      end
      S_R1: begin
        if (byte_end) begin
          if (!rx_q[7]) begin
            case (sel_q)
              SEL_CMD0: begin
                if (rx_q == 8'h01) begin go_gap = 1'b1; next_sel = SEL_CMD8; end
                else begin go_err = 1'b1; err_val = 3'd1; end
              end
              SEL_CMD8: begin
                if (rx_q == 8'h01) begin state_d = S_R7; byte_d = 3'd0; end
                else begin go_err = 1'b1; err_val = 3'd2; end
              end
              SEL_CMD55: begin
                if (rx_q == 8'h00 || rx_q == 8'h01) begin go_gap = 1'b1; next_sel = SEL_ACMD41; end
                else begin go_err = 1'b1; err_val = 3'd4; end
              end
              default: begin
                if (rx_q == 8'h00) go_done = 1'b1;
                else if (rx_q == 8'h01) begin
                  if (try_q == TRY_W'(ACMD41_TRIES - 1)) begin go_err = 1'b1; err_val = 3'd3; end
                  else begin try_d = try_q + TRY_W'(1); go_gap = 1'b1; next_sel = SEL_CMD55; end
                end else begin go_err = 1'b1; err_val = 3'd4; end
              end
            endcase
          end else if (ncr_q == NCR_W'(NCR_MAX - 1)) begin
            go_err  = 1'b1;
            err_val = (sel_q == SEL_CMD0) ? 3'd1 : (sel_q == SEL_CMD8) ? 3'd2 : 3'd4;
          end else begin
            ncr_d = ncr_q + NCR_W'(1);
          end
        end
      end
      S_R7: begin
        if (byte_end) begin
          r7_d   = rx_q[3:0];
          byte_d = byte_q + 3'd1;
          if (byte_q == 3'd3) begin
            if ({r7_q, rx_q} == 12'h1AA) begin go_gap = 1'b1; next_sel = SEL_CMD55; end
            else begin go_err = 1'b1; err_val = 3'd2; end
          end
        end
      end
      default: ;
    endcase

    if (go_gap) begin
      state_d = S_GAP;
      sel_d   = next_sel;
      cs_n_d  = 1'b1;
      tx_d    = 8'hFF;
    end
    if (go_err || go_done) begin
      state_d = go_err ? S_ERR : S_DONE;
      cs_n_d  = 1'b1;
      tx_d    = 8'hFF;
      if (go_err) err_code_d = err_val;
    end

    // losing lock abandons everything, including any partial byte
    if (!lock_sync_q) begin
      state_d    = S_WAIT_LOCK;
      sel_d      = SEL_CMD0;
      div_d      = '0;
      sck_d      = 1'b0;
      cs_n_d     = 1'b1;
      tx_d       = 8'hFF;
      rx_d       = 8'hFF;
      bit_d      = 3'd0;
      byte_d     = 3'd0;
      dummy_d    = 8'd0;
      ncr_d      = '0;
      try_d      = '0;
      r7_d       = 4'd0;
      err_code_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      state_q     <= S_WAIT_LOCK;
      sel_q       <= SEL_CMD0;
      div_q       <= '0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      tx_q        <= 8'hFF;
      rx_q        <= 8'hFF;
      bit_q       <= 3'd0;
      byte_q      <= 3'd0;
      dummy_q     <= 8'd0;
      ncr_q       <= '0;
      try_q       <= '0;
      r7_q        <= 4'd0;
      err_code_q  <= 3'd0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      div_q       <= div_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      dummy_q     <= dummy_d;
      ncr_q       <= ncr_d;
      try_q       <= try_d;
      r7_q        <= r7_d;
      err_code_q  <= err_code_d;
    end
  end

  assign sd_sck    = sck_q;
  assign sd_cs_n   = cs_n_q;
  assign sd_mosi   = tx_q[7];
  assign init_done = (state_q == S_DONE);
  assign init_err  = (state_q == S_ERR);
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_init_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sd_spi_init_ctrl : directed bench with a behavioural SPI-mode SD card
// Rev 1.0
// ============================================================================
module tb_sd_spi_init_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       sd_miso;
  logic       sd_sck, sd_cs_n, sd_mosi;
  logic       init_done, init_err;
  logic [2:0] err_code;

  sd_spi_init_ctrl #(
    .CLK_DIV(2), .DUMMY_CLKS(80), .NCR_MAX(8), .ACMD41_TRIES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .sd_miso(sd_miso),
    .sd_sck(sd_sck), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi),
    .init_done(init_done), .init_err(init_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- card model ----------------
  int          card_bits, frm_n, post_bytes, pre_pulses, pre_mosi0;
  int          n_cmd0, n_cmd8, n_cmd55, n_acmd41;
  bit          seen_cs;
  logic [7:0]  card_rx, card_tx;
  logic [7:0]  frm [6];
  logic [7:0]  resp_q [$];
  logic [7:0]  acmd_list [$];
  logic [47:0] cmd0_frame, cmd8_frame, acmd41_frame;
  bit          cmd0_silent;
  logic [7:0]  r1_cmd8;
  logic [31:0] r7_val;

  task automatic card_reset();
    card_bits = 0; frm_n = 0; post_bytes = 0; pre_pulses = 0; pre_mosi0 = 0;
    n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0; n_acmd41 = 0; seen_cs = 0;
    card_rx = 8'hFF; card_tx = 8'hFF;
    resp_q.delete(); acmd_list.delete();
    cmd0_frame = '0; cmd8_frame = '0; acmd41_frame = '0;
    cmd0_silent = 0; r1_cmd8 = 8'h01; r7_val = 32'h0000_01AA;
    sd_miso = 1'b1;
  endtask

  task automatic card_cmd();
    logic [47:0] f;
    logic [7:0]  r;
    f = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    post_bytes = 0;
    case (frm[0])
      8'h40: begin
        n_cmd0++; cmd0_frame = f;
        if (!cmd0_silent) begin resp_q.push_back(8'hFF); resp_q.push_back(8'h01); end
      end
      8'h48: begin
        n_cmd8++; cmd8_frame = f;
        resp_q.push_back(8'hFF); resp_q.push_back(r1_cmd8);
        if (r1_cmd8 == 8'h01)
          for (int i = 0; i < 4; i++) resp_q.push_back(r7_val[8*(3-i) +: 8]);
      end
      8'h77: begin
        n_cmd55++; resp_q.push_back(8'hFF); resp_q.push_back(8'h01);
      end
      8'h69: begin
        n_acmd41++; acmd41_frame = f;
        r = (acmd_list.size() > 0) ? acmd_list.pop_front() : 8'h01;
        resp_q.push_back(8'hFF); resp_q.push_back(r);
      end
      default: ;
    endcase
  endtask

  always @(posedge sd_sck) begin
    if (sd_cs_n) begin
      card_bits = 0; frm_n = 0; resp_q.delete();
      if (!seen_cs) begin
        pre_pulses++;
        if (!sd_mosi) pre_mosi0++;
      end
    end else begin
      seen_cs = 1;
      card_rx = {card_rx[6:0], sd_mosi};
      card_bits++;
      if (card_bits == 8) begin
        card_bits = 0;
        if (frm_n < 6 && (frm_n > 0 || card_rx[7:6] == 2'b01)) begin
          frm[frm_n] = card_rx;
          frm_n++;
          if (frm_n == 6) card_cmd();
        end else begin
          post_bytes++;
        end
      end
    end
  end

  always @(negedge sd_sck) begin
    if (sd_cs_n) sd_miso = 1'b1;
    else begin
      if (card_bits == 0) card_tx = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
      sd_miso = card_tx[7];
      card_tx = {card_tx[6:0], 1'b1};
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    card_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (init_done || init_err) break;
    end
    check_eq({tag, "_finished"}, 64'(init_done || init_err), 64'd1);
  endtask

  task automatic check_idle_pins(input string tag);
    check_eq({tag, "_sck"},  64'(sd_sck),  64'd0);
    check_eq({tag, "_cs_n"}, 64'(sd_cs_n), 64'd1);
    check_eq({tag, "_mosi"}, 64'(sd_mosi), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    pll_lock = 1'b1;
    card_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle_pins("reset");
    check_eq("reset_done", 64'(init_done), 64'd0);
    check_eq("reset_err",  64'(init_err),  64'd0);
    check_eq("reset_code", 64'(err_code),  64'd0);

    // 1: normal bring-up, ACMD41 answers 01, 01, 00
    card_reset();
    acmd_list.push_back(8'h01); acmd_list.push_back(8'h01); acmd_list.push_back(8'h00);
    release_reset();
    wait_end("t1");
    check_eq("t1_pre_cs_pulses", 64'(pre_pulses), 64'd88);
    check_eq("t1_pre_mosi_low",  64'(pre_mosi0),  64'd0);
    check_eq("t1_cmd0_frame",   64'(cmd0_frame),   64'h40_0000_0000_95);
    check_eq("t1_cmd8_frame",   64'(cmd8_frame),   64'h48_0000_01AA_87);
    check_eq("t1_acmd41_frame", 64'(acmd41_frame), 64'h69_4000_0000_01);
    check_eq("t1_n_cmd55",  64'(n_cmd55),  64'd3);
    check_eq("t1_n_acmd41", 64'(n_acmd41), 64'd3);
    check_eq("t1_r1_bytes", 64'(post_bytes), 64'd2);
    check_eq("t1_done", 64'(init_done), 64'd1);
    check_eq("t1_err",  64'(init_err),  64'd0);
    check_eq("t1_code", 64'(err_code),  64'd0);
    repeat (20) @(negedge clk);
    check_idle_pins("t1_idle");
    check_eq("t1_done_held", 64'(init_done), 64'd1);

    // 2: card never answers CMD0
    hold_reset();
    cmd0_silent = 1;
    release_reset();
    wait_end("t2");
    check_eq("t2_polled", 64'(post_bytes), 64'd8);
    check_eq("t2_err",  64'(init_err),  64'd1);
    check_eq("t2_done", 64'(init_done), 64'd0);
    check_eq("t2_code", 64'(err_code),  64'd1);
    check_eq("t2_cs_n", 64'(sd_cs_n),   64'd1);
    check_eq("t2_n_cmd8", 64'(n_cmd8),  64'd0);

    // 3a: bad CMD8 echo
    hold_reset();
    r7_val = 32'h0000_0155;
    release_reset();
    wait_end("t3a");
    check_eq("t3a_code", 64'(err_code), 64'd2);
    check_eq("t3a_err",  64'(init_err), 64'd1);
    check_eq("t3a_n_cmd55", 64'(n_cmd55), 64'd0);

    // 3b: CMD8 illegal-command R1
    hold_reset();
    r1_cmd8 = 8'h05;
    release_reset();
    wait_end("t3b");
    check_eq("t3b_code", 64'(err_code), 64'd2);
    check_eq("t3b_r1_bytes", 64'(post_bytes), 64'd2);

    // 4: ACMD41 never ready
    hold_reset();
    release_reset();
    wait_end("t4");
    check_eq("t4_code", 64'(err_code), 64'd3);
    check_eq("t4_done", 64'(init_done), 64'd0);
    check_eq("t4_n_cmd55",  64'(n_cmd55),  64'd3);
    check_eq("t4_n_acmd41", 64'(n_acmd41), 64'd3);

    // 5: lock loss inside CMD8 byte 3, then re-lock
    hold_reset();
    acmd_list.push_back(8'h01); acmd_list.push_back(8'h01); acmd_list.push_back(8'h00);
    release_reset();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (frm_n == 2 && frm[0] == 8'h48 && card_bits == 3) break;
    end
    check_eq("t5_mid_cmd8_cs_n", 64'(sd_cs_n), 64'd0);
    pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_drop_cs_n", 64'(sd_cs_n), 64'd1);
    check_eq("t5_drop_sck",  64'(sd_sck),  64'd0);
    repeat (10) @(negedge clk);
    check_idle_pins("t5_unlocked");
    card_reset();
    acmd_list.push_back(8'h01); acmd_list.push_back(8'h01); acmd_list.push_back(8'h00);
    pll_lock = 1'b1;
    wait_end("t5");
    check_eq("t5_relock_pulses", 64'(pre_pulses), 64'd88);
    check_eq("t5_done", 64'(init_done), 64'd1);
    check_eq("t5_code", 64'(err_code),  64'd0);

    // 6: asynchronous reset while polling CMD0 R1
    hold_reset();
    release_reset();
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (n_cmd0 == 1) break;
    end
    repeat (10) @(negedge clk);
    #2;
    check_eq("t6_mid_r1_cs_n", 64'(sd_cs_n), 64'd0);
    rst_n = 1'b0;
    #1;
    check_idle_pins("t6_async");
    check_eq("t6_done", 64'(init_done), 64'd0);
    check_eq("t6_err",  64'(init_err),  64'd0);
    check_eq("t6_code", 64'(err_code),  64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
